// File: rtl/sub_atom_driver.sv
// sub_atom_driver: issue-side partner of the stateful 'sub' atom.
// Accepts packets over valid/ready, holds the atom config bank and drives every atom input
// from registers. On cycles without an accepted packet it issues a HOLD op that leaves the
// atom state unchanged. Each packet's atom read/write pair is captured LAT edges after issue
// into an in-order result FIFO with a valid/ready output.
// Optional feature macro: STATE_CHECK_EN (shadow-tracks the atom state and flags a sticky
// mismatch on o__state_err). Without it o__state_err is tied low.
module sub_atom_driver #(
  parameter int unsigned DEPTH = 4,  // result FIFO entries and credit limit (>= 2)
  parameter int unsigned LAT   = 2   // edges from issue to capture
) (
  input  logic        clk,
  input  logic        rst_n,
  // packet input
  input  logic        i__in_valid,
  output logic        o__in_ready,
  input  logic [31:0] i__in_pkt_1,
  input  logic [31:0] i__in_pkt_2,
  // result output
  output logic        o__out_valid,
  input  logic        i__out_ready,
  output logic [31:0] o__out_read,
  output logic [31:0] o__out_write,
  // config bank
  input  logic        i__cfg_we,
  input  logic [3:0]  i__cfg_addr,
  input  logic [31:0] i__cfg_wdata,
  // atom drive
  output logic [31:0] o__atom_pkt_1,
  output logic [31:0] o__atom_pkt_2,
  output logic [31:0] o__atom_cons_1,
  output logic [31:0] o__atom_cons_2,
  output logic [31:0] o__atom_cons_3,
  output logic [31:0] o__atom_cons_4,
  output logic [31:0] o__atom_cons_5,
  output logic        o__atom_sel_1,
  output logic [1:0]  o__atom_sel_2,
  output logic        o__atom_sel_3,
  output logic [1:0]  o__atom_sel_4,
  output logic        o__atom_sel_5,
  output logic [1:0]  o__atom_sel_6,
  output logic [1:0]  o__atom_sel_7,
  output logic [1:0]  o__atom_sel_8,
  output logic [1:0]  o__atom_rel_opcode,
  // atom response
  input  logic [31:0] i__atom_read,
  input  logic [31:0] i__atom_write,
  output logic        o__state_err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned CrdW = $clog2(DEPTH + LAT + 1);

  logic              accept;
  logic              push;
  logic              pop;
  logic              run_q;

  logic [31:0]       cons_q [5];
  logic [14:0]       sel_word_q;

  logic [31:0]       pkt_1_q, pkt_2_q;
  logic [31:0]       acons_q [5];
  logic              sel_1_q, sel_3_q, sel_5_q;
  logic [1:0]        sel_2_q, sel_4_q, sel_6_q, sel_7_q, sel_8_q, rel_q;

  logic [LAT-1:0]    tag_q, tag_d;
  logic [CrdW-1:0]   inflight_cnt;
  logic [CrdW-1:0]   credits;

  logic [31:0]       fifo_rd_q [DEPTH];
  logic [31:0]       fifo_wr_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover buffered results plus packets still travelling through the atom, so the
  // FIFO can never overflow even with the output stalled.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < int'(LAT); i++) begin
      inflight_cnt = inflight_cnt + CrdW'(tag_q[i]);
    end
    credits     = CrdW'(count_q) + inflight_cnt;
    o__in_ready = run_q && (credits < CrdW'(DEPTH));
    accept      = i__in_valid && o__in_ready;
  end

  // Ready is held low while in reset and released one edge later from registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Config bank; a write is visible from its own edge, so a same-edge accept sees old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) cons_q[i] <= '0;
      sel_word_q <= '0;
    end else if (i__cfg_we) begin
      for (int i = 0; i < 5; i++) begin
        if (i__cfg_addr == 4'(i)) cons_q[i] <= i__cfg_wdata;
      end
      if (i__cfg_addr == 4'd5) sel_word_q <= i__cfg_wdata[14:0];
    end
  end

  // Atom input registers: full packet+config on accept, else a HOLD op (state + 0 - 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_1_q <= '0;
      pkt_2_q <= '0;
      for (int i = 0; i < 5; i++) acons_q[i] <= '0;
      sel_1_q <= 1'b0;
      sel_2_q <= '0;
      sel_3_q <= 1'b0;
      sel_4_q <= '0;
      sel_5_q <= 1'b0;
      sel_6_q <= '0;
      sel_7_q <= '0;
      sel_8_q <= '0;
      rel_q   <= '0;
    end else if (accept) begin
      pkt_1_q <= i__in_pkt_1;
      pkt_2_q <= i__in_pkt_2;
      for (int i = 0; i < 5; i++) acons_q[i] <= cons_q[i];
      sel_1_q <= sel_word_q[0];
      sel_2_q <= sel_word_q[2:1];
      sel_3_q <= sel_word_q[3];
      sel_4_q <= sel_word_q[5:4];
      sel_5_q <= sel_word_q[6];
      sel_6_q <= sel_word_q[8:7];
      sel_7_q <= sel_word_q[10:9];
      sel_8_q <= sel_word_q[12:11];
      rel_q   <= sel_word_q[14:13];
    end else begin
      // cons, sel_1, sel_2 and rel_opcode keep their last values; either branch of the
      // atom's relational test then reduces to state + 0 - 0.
      pkt_1_q <= '0;
      pkt_2_q <= '0;
      sel_3_q <= 1'b0;
      sel_4_q <= '0;
      sel_5_q <= 1'b0;
      sel_6_q <= '0;
      sel_7_q <= '0;
      sel_8_q <= '0;
    end
  end

  assign o__atom_pkt_1      = pkt_1_q;
  assign o__atom_pkt_2      = pkt_2_q;
  assign o__atom_cons_1     = acons_q[0];
  assign o__atom_cons_2     = acons_q[1];
  assign o__atom_cons_3     = acons_q[2];
  assign o__atom_cons_4     = acons_q[3];
  assign o__atom_cons_5     = acons_q[4];
  assign o__atom_sel_1      = sel_1_q;
  assign o__atom_sel_2      = sel_2_q;
  assign o__atom_sel_3      = sel_3_q;
  assign o__atom_sel_4      = sel_4_q;
  assign o__atom_sel_5      = sel_5_q;
  assign o__atom_sel_6      = sel_6_q;
  assign o__atom_sel_7      = sel_7_q;
  assign o__atom_sel_8      = sel_8_q;
  assign o__atom_rel_opcode = rel_q;

  // In-flight tag pipe: bit 0 set on accept, oldest bit marks the capture edge.
  always_comb begin
    tag_d    = tag_q << 1;
    tag_d[0] = accept;
  end

  // In-flight tag register; cleared by reset so in-flight packets are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= '0;
    else        tag_q <= tag_d;
  end

  assign push         = tag_q[LAT-1];
  assign o__out_valid = (count_q != '0);
  assign pop          = o__out_valid && i__out_ready;
  assign o__out_read  = fifo_rd_q[rd_ptr_q];
  assign o__out_write = fifo_wr_q[rd_ptr_q];

  // Occupancy next-state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Result FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_rd_q[i] <= '0;
        fifo_wr_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_rd_q[wr_ptr_q] <= i__atom_read;
        fifo_wr_q[wr_ptr_q] <= i__atom_write;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

`ifdef STATE_CHECK_EN
  logic [31:0] shadow_q;
  logic        shadow_vld_q;
  logic        err_q;

  // The atom's read this cycle must equal the write it reported on the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      shadow_q     <= i__atom_write;
      shadow_vld_q <= 1'b1;
      if (shadow_vld_q && (i__atom_read != shadow_q)) err_q <= 1'b1;
    end
  end

  assign o__state_err = err_q;
`else
  assign o__state_err = 1'b0;
`endif

endmodule
